// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, MSB first, paced by a bit-rate enable.
module piso_shift_tx #(
   parameter int COUNT = 8
) (
   input  logic             clk,
   input  logic             i_sclr,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic [COUNT-1:0] i_data,
   output logic             o_ready,
   output logic             o_bit,
   output logic             o_strobe,
   output logic             o_busy,
   output logic             o_done
);
   localparam int CW = $clog2(COUNT + 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           r_state, w_state;
   logic [COUNT-1:0] r_data, w_data;
   logic [CW-1:0]    r_cnt, w_cnt;
   logic             r_done, w_done, w_accept, w_shift;
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_data  <= w_data;
         r_cnt   <= w_cnt;
         r_done  <= w_done;
      end
   end
   // acceptance only happens in IDLE, so an enable in that cycle never shifts
   always_comb begin
      w_accept = r_state == IDLE && i_valid;
      w_shift  = r_state == SHIFT && i_en;
      w_done   = w_shift && r_cnt == CW'(1);
      w_state  = w_accept ? SHIFT : w_done ? IDLE : r_state;
      w_data   = w_accept ? i_data : w_shift ? {r_data[COUNT-2:0], 1'b0} : r_data;
      w_cnt    = w_accept ? CW'(COUNT) : w_shift ? r_cnt - CW'(1) : r_cnt;
      o_ready  = r_state == IDLE;
      o_busy   = r_state == SHIFT;
      o_bit    = r_state == SHIFT && r_data[COUNT-1];
      o_strobe = w_shift;
      o_done   = r_done;
   end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: scoreboard bench; driver queues expected bits per word, monitor checks strobes, done and a loopback receiver.
module tb_piso_shift_tx;
   logic       clk = 1'b0;
   logic       i_sclr = 1'b1;
   logic       i_en = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       o_ready, o_bit, o_strobe, o_busy, o_done;
   typedef struct {
      logic       b;
      logic       last;
      logic [7:0] w;
   } exp_t;
   exp_t       q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic       started = 1'b0;
   logic [7:0] rx = 8'h00;
   piso_shift_tx #(.COUNT(8)) dut (
      .clk(clk), .i_sclr(i_sclr), .i_en(i_en), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_bit(o_bit), .o_strobe(o_strobe), .o_busy(o_busy), .o_done(o_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (o_strobe === 1'b1) rx <= {rx[6:0], o_bit};
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) q.push_back('{b: w[i], last: i == 0, w: w});
   endtask
   // i_en pulses once every 'period' cycles while shifting; acceptance cycle has i_en=1
   task automatic send_word(input logic [7:0] w, input int period);
      int k;
      k = 0;
      while (!o_ready && k < 100) begin tick(); k++; end
      if (k >= 100) check("ready_timeout", 0, 1);
      push_word(w);
      i_valid = 1'b1;
      i_data  = w;
      i_en    = 1'b1;
      tick();
      i_valid = 1'b0;
      k = 0;
      while (o_busy && k < 200) begin
         i_data = 8'($urandom);
         i_en   = (k % period) == period - 1;
         tick();
         k++;
      end
      if (k >= 200) check("shift_timeout", 0, 1);
      i_en = 1'b0;
   endtask
   initial begin : monitor
      logic       pend, prev_busy, prev_strobe, prev_bit;
      logic [7:0] pend_w;
      exp_t       e;
      pend = 1'b0; pend_w = 8'h00;
      prev_busy = 1'b0; prev_strobe = 1'b0; prev_bit = 1'b0;
      wait (started);
      forever begin
         @(negedge clk);
         check("ready_vs_busy", o_ready, !o_busy);
         if (!o_busy) begin
            check("idle_bit", o_bit, 0);
            check("idle_strobe", o_strobe, 0);
         end
         check("done", o_done, pend);
         if (pend && o_done) check("rx_word", rx, pend_w);
         pend = 1'b0;
         if (o_busy && prev_busy && !prev_strobe) check("bit_hold", o_bit, prev_bit);
         if (o_strobe) begin
            if (q.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
               e = q.pop_front();
               check("bit", o_bit, e.b);
               if (e.last) begin
                  pend   = 1'b1;
                  pend_w = e.w;
               end
            end
         end
         prev_busy = o_busy; prev_strobe = o_strobe; prev_bit = o_bit;
      end
   end
   initial begin : driver
      int k;
      // reset wins over a simultaneous offer and enable
      i_valid = 1'b1; i_en = 1'b1; i_data = 8'hA5;
      tick();
      started = 1'b1;
      tick();
      i_sclr = 1'b0; i_valid = 1'b0; i_en = 1'b0;
      check("reset_ready", o_ready, 1);
      check("reset_busy", o_busy, 0);
      for (int i = 0; i < 5; i++) begin i_en = i[0]; tick(); end
      i_en = 1'b0;
      check("idle_busy", o_busy, 0);
      send_word(8'hA5, 1);
      tick();
      send_word(8'h3C, 3);
      tick();
      // valid held: second word must wait for the done cycle of the first
      push_word(8'hFF);
      push_word(8'h01);
      i_valid = 1'b1; i_data = 8'hFF; i_en = 1'b1;
      tick();
      i_data = 8'h01;
      k = 0;
      while (!o_done && k < 50) begin tick(); k++; end
      check("b2b_done_seen", o_done, 1);
      check("b2b_ready_on_done", o_ready, 1);
      tick();
      i_valid = 1'b0;
      check("b2b_second_accepted", o_busy, 1);
      k = 0;
      while (o_busy && k < 50) begin tick(); k++; end
      check("b2b_finished", o_busy, 0);
      tick();
      // abort after three strobes
      push_word(8'hF0);
      i_valid = 1'b1; i_data = 8'hF0; i_en = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(); tick(); tick();
      check("abort_q_left", q.size(), 5);
      q.delete();
      i_sclr = 1'b1; i_en = 1'b0;
      tick();
      i_sclr = 1'b0; i_en = 1'b1;
      check("abort_idle", o_busy, 0);
      check("abort_bit", o_bit, 0);
      tick(); tick();
      i_en = 1'b0;
      send_word(8'h81, 1);
      tick();
      for (int n = 0; n < 200; n++) send_word(8'($urandom), 1 + (n % 2));
      tick(); tick(); tick();
      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
